// File: rtl/axi_ptgen_sequencer_if.sv
// Handshake bundle between the sequencer and its AXI traffic-generator masters.
// The master modport is the sequencer side; the slave modport is the generator side.
interface axi_ptgen_sequencer_if #(
   parameter int NUM_MST = 4
) ();
   logic [NUM_MST-1:0] INIT_AXI_TXN;
   logic [NUM_MST-1:0] TXN_DONE;
   logic [NUM_MST-1:0] ERROR;

   modport master (output INIT_AXI_TXN, input TXN_DONE, input ERROR);
   modport slave  (input INIT_AXI_TXN, output TXN_DONE, output ERROR);
endinterface

// File: rtl/axi_ptgen_sequencer.sv
// Runs enabled traffic-generator masters in turn for LOOPS sweeps and collects their status.
// Build option SEQ_STOP_ON_ERR_EN: end the run at the first recorded error or timeout.
//
// state  | meaning
// IDLE   | waiting for START; results of the last run held
// INIT   | INIT_AXI_TXN pulse to CUR_MST
// WAIT   | waiting for a fresh TXN_DONE from CUR_MST, timeout running
// NEXT   | choose the next master, count completed sweeps
// FINISH | publish DONE/PASS, drop BUSY
module axi_ptgen_sequencer #(
   parameter int NUM_MST        = 4,
   parameter int INIT_PULSE_CYC = 2,
   parameter int TIMEOUT_CYC    = 4096,
   parameter int LOOP_W         = 8,
   localparam int CW            = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
   input  logic                 ACLK,
   input  logic                 ARESET,
   input  logic                 START,
   input  logic [LOOP_W-1:0]    LOOPS,
   input  logic [NUM_MST-1:0]   MST_EN,
   axi_ptgen_sequencer_if.master mst,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 PASS,
   output logic [NUM_MST-1:0]   ERR_MASK,
   output logic [NUM_MST-1:0]   TIMEOUT_MASK,
   output logic [CW-1:0]        CUR_MST,
   output logic [LOOP_W-1:0]    RUN_CNT
);
   localparam int PW = (INIT_PULSE_CYC > 1) ? $clog2(INIT_PULSE_CYC) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [NUM_MST-1:0] ONE_HOT0 = NUM_MST'(1);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_NEXT, S_FINISH} state_t;
   typedef struct packed {
      logic          vld;
      logic [CW-1:0] idx;
   } pick_t;

   state_t              state_q, state_d;
   logic [NUM_MST-1:0]  act_q, act_d;
   logic [LOOP_W-1:0]   loops_q, loops_d;
   logic [CW-1:0]       cur_q, cur_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic                armed_q, armed_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic [NUM_MST-1:0]  err_q, err_d;
   logic [NUM_MST-1:0]  to_q, to_d;
   logic [LOOP_W-1:0]   run_q, run_d;

   pick_t               lo_en, lo_act, nx_act;
   logic [LOOP_W-1:0]   run_inc;
   logic                stop_hit;

   // Lowest set bit of m at or above position from.
   function automatic pick_t first_set(input logic [NUM_MST-1:0] m, input int from);
      pick_t r;
      r = '0;
      for (int i = NUM_MST - 1; i >= 0; i--) begin
         if (m[i] && (i >= from)) begin
            r.vld = 1'b1;
            r.idx = CW'(i);
         end
      end
      return r;
   endfunction

   always_comb begin
      lo_en   = first_set(MST_EN, 0);
      lo_act  = first_set(act_q, 0);
      nx_act  = first_set(act_q, int'(cur_q) + 1);
      run_inc = (&run_q) ? run_q : run_q + LOOP_W'(1);
`ifdef SEQ_STOP_ON_ERR_EN
      stop_hit = |err_q;
`else
      stop_hit = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      loops_d = loops_q;
      cur_d   = cur_q;
      pcnt_d  = pcnt_q;
      tcnt_d  = tcnt_q;
      armed_d = armed_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      err_d   = err_q;
      to_d    = to_q;
      run_d   = run_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               to_d    = '0;
               run_d   = '0;
               busy_d  = 1'b1;
               act_d   = MST_EN;
               loops_d = (LOOPS == '0) ? LOOP_W'(1) : LOOPS;
               if (lo_en.vld) begin
                  cur_d   = lo_en.idx;
                  pcnt_d  = PW'(INIT_PULSE_CYC - 1);
                  state_d = S_INIT;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_INIT: begin
            armed_d = 1'b0;
            tcnt_d  = TW'(TIMEOUT_CYC - 1);
            if (pcnt_q == '0) state_d = S_WAIT;
            else              pcnt_d  = pcnt_q - PW'(1);
         end
         S_WAIT: begin
            tcnt_d = tcnt_q - TW'(1);
            if (!mst.TXN_DONE[cur_q]) armed_d = 1'b1;
            // A done level is only trusted after it was seen low in this wait.
            if (armed_q && mst.TXN_DONE[cur_q]) begin
               err_d[cur_q] = err_q[cur_q] | mst.ERROR[cur_q];
               state_d      = S_NEXT;
            end else if (tcnt_q == '0) begin
               to_d[cur_q]  = 1'b1;
               err_d[cur_q] = 1'b1;
               act_d[cur_q] = 1'b0;
               state_d      = S_NEXT;
            end
         end
         S_NEXT: begin
            if (stop_hit) begin
               state_d = S_FINISH;
            end else if (nx_act.vld) begin
               cur_d   = nx_act.idx;
               pcnt_d  = PW'(INIT_PULSE_CYC - 1);
               state_d = S_INIT;
            end else begin
               run_d = run_inc;
               if ((run_inc >= loops_q) || (act_q == '0)) begin
                  state_d = S_FINISH;
               end else begin
                  cur_d   = lo_act.idx;
                  pcnt_d  = PW'(INIT_PULSE_CYC - 1);
                  state_d = S_INIT;
               end
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            pass_d  = (err_q == '0);
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= S_IDLE;
         act_q   <= '0;
         loops_q <= '0;
         cur_q   <= '0;
         pcnt_q  <= '0;
         tcnt_q  <= '0;
         armed_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         to_q    <= '0;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         loops_q <= loops_d;
         cur_q   <= cur_d;
         pcnt_q  <= pcnt_d;
         tcnt_q  <= tcnt_d;
         armed_q <= armed_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         to_q    <= to_d;
         run_q   <= run_d;
      end
   end

   assign mst.INIT_AXI_TXN = (state_q == S_INIT) ? (ONE_HOT0 << cur_q) : '0;
   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign PASS         = pass_q;
   assign ERR_MASK     = err_q;
   assign TIMEOUT_MASK = to_q;
   assign CUR_MST      = cur_q;
   assign RUN_CNT      = run_q;
endmodule

// File: doc/axi_ptgen_sequencer.md
Name: axi_ptgen_sequencer

Overview:
- Scheduler for up to NUM_MST AXI master traffic-generator ports. Each port uses the INIT_AXI_TXN / TXN_DONE / ERROR handshake.
- On START, it runs each enabled master in turn: pulses init, waits for done, records error or timeout. It repeats the sweep LOOPS times.
- Sits beside the AXI master ports in the block design and replaces per-master bench init pulsing with one start/status interface.

Parameters:
- NUM_MST, 4, number of master handshake ports (1..16).
- INIT_PULSE_CYC, 2, cycles INIT_AXI_TXN is held high per launch (>=1).
- TIMEOUT_CYC, 4096, maximum cycles in WAIT before a master is declared hung.
- LOOP_W, 8, width of the LOOPS and RUN_CNT fields.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- START  in  1  level-sampled; launches a run when the sequencer is idle.
- LOOPS  in  LOOP_W  number of sweeps; 0 is treated as 1. Latched at START.
- MST_EN  in  NUM_MST  per-master enable mask. Latched at START.
- INIT_AXI_TXN  out  NUM_MST  one-hot init pulse to the masters.
- TXN_DONE  in  NUM_MST  level done from each master; master clears it after init.
- ERROR  in  NUM_MST  level error from each master; valid when TXN_DONE is high.
- BUSY  out  1  high from the cycle after START acceptance until DONE is asserted.
- DONE  out  1  sticky; high after run completion until the next accepted START.
- PASS  out  1  valid while DONE is high; 1 iff ERR_MASK == 0.
- ERR_MASK  out  NUM_MST  sticky per-master flag: error or timeout.
- TIMEOUT_MASK  out  NUM_MST  sticky per-master timeout flag.
- CUR_MST  out  clog2(NUM_MST) (min 1)  index of the master being served.
- RUN_CNT  out  LOOP_W  number of completed sweeps.

Behaviour:
- Reset values (at the first ACLK edge with ARESET=1): state IDLE; all outputs 0.
- Reset mid-run drops INIT_AXI_TXN at that edge. No run state is retained.
- States: IDLE, INIT, WAIT, NEXT, FINISH.
- IDLE:
  - START=1 clears DONE, ERR_MASK, TIMEOUT_MASK and RUN_CNT.
  - Latches MST_EN into act_mask. Latches max(LOOPS,1).
  - Selects the lowest set bit of act_mask as CUR_MST and goes to INIT.
  - If act_mask == 0, goes straight to FINISH.
  - START while not IDLE is ignored.
- INIT:
  - INIT_AXI_TXN[CUR_MST]=1 for exactly INIT_PULSE_CYC cycles, starting the cycle after START or NEXT. Other bits stay 0.
  - Clears the armed flag and the timeout counter, then goes to WAIT.
- WAIT:
  - Counter increments every cycle.
  - TXN_DONE[CUR_MST]==0 sets armed. A stale done from the previous run is never accepted.
  - armed && TXN_DONE[CUR_MST]==1: ERR_MASK[CUR_MST] |= ERROR[CUR_MST]; go to NEXT.
  - Counter == TIMEOUT_CYC-1 without completion: set TIMEOUT_MASK and ERR_MASK bits; clear act_mask[CUR_MST] so the master is skipped in later sweeps; go to NEXT.
  - If completion and timeout occur in the same cycle, completion wins.
- NEXT (1 cycle):
  - Picks the next set bit of act_mask above CUR_MST.
  - If none is left, increments RUN_CNT (no wrap; RUN_CNT saturates at 2^LOOP_W-1).
  - If RUN_CNT reaches the latched loop count, or act_mask is now 0, goes to FINISH.
  - Otherwise wraps to the lowest set bit and goes to INIT.
- FINISH (1 cycle): DONE=1, PASS=(ERR_MASK==0), BUSY=0, then IDLE.
- Mid-run changes to MST_EN and LOOPS have no effect on the current run.

Optional Feature:
- SEQ_STOP_ON_ERR_EN.
- Defined: the first ERR_MASK bit set in WAIT forces NEXT to go to FINISH. The offending master's results are recorded; no further masters are launched; RUN_CNT is not incremented for the partial sweep.
- Undefined: all enabled masters run every sweep regardless of errors.

Test Plan:
- MST_EN=4'b0101, LOOPS=1, masters 0/2 finish without error -> init pulses on bit0 then bit2, each 2 cycles wide; DONE=1, PASS=1, RUN_CNT=1, ERR_MASK=0.
- MST_EN=4'b1111, LOOPS=3, master 1 asserts ERROR with done in sweep 2 -> 12 init pulses total; ERR_MASK=4'b0010, TIMEOUT_MASK=0, PASS=0, RUN_CNT=3. With SEQ_STOP_ON_ERR_EN: 6 pulses, RUN_CNT=1.
- Master 3 never raises done, TIMEOUT_CYC=16, LOOPS=2 -> WAIT lasts 16 cycles; TIMEOUT_MASK=4'b1000; master 3 is pulsed only in sweep 1; DONE=1, RUN_CNT=2.
- Master 0 TXN_DONE held high from the prior run and cleared 3 cycles after init, then re-raised -> completion only after re-rise, not on the stale level.
- MST_EN=0, START=1 -> DONE=1, PASS=1 two cycles later; no INIT_AXI_TXN activity. START while BUSY -> no effect.
- ARESET=1 during INIT of master 2 -> next cycle INIT_AXI_TXN=0, BUSY=0, DONE=0, masks 0; a new START runs normally.
